// File: rtl/ahb_interconnect_if.sv
// ahb_interconnect_if: manager-side and satellite-side AHB-Lite signals of the interconnect
interface ahb_interconnect_if #(
  parameter int NUM_MGR = 2,
  parameter int NUM_SAT = 4
);
  localparam int MW = NUM_MGR > 1 ? $clog2(NUM_MGR) : 1;
  logic                  ovr_en;
  logic [MW-1:0]         ovr_sel;
  logic [32*NUM_MGR-1:0] m_haddr;
  logic [2*NUM_MGR-1:0]  m_htrans;
  logic [NUM_MGR-1:0]    m_hwrite;
  logic [3*NUM_MGR-1:0]  m_hsize;
  logic [3*NUM_MGR-1:0]  m_hburst;
  logic [32*NUM_MGR-1:0] m_hwdata;
  logic [32*NUM_MGR-1:0] m_hrdata;
  logic [NUM_MGR-1:0]    m_hready;
  logic [NUM_MGR-1:0]    m_hresp;
  logic [31:0]           s_haddr;
  logic [1:0]            s_htrans;
  logic                  s_hwrite;
  logic [2:0]            s_hsize;
  logic [2:0]            s_hburst;
  logic [31:0]           s_hwdata;
  logic [NUM_SAT-1:0]    s_hsel;
  logic                  s_hready;
  logic [32*NUM_SAT-1:0] s_hrdata;
  logic [NUM_SAT-1:0]    s_hreadyout;
  logic [NUM_SAT-1:0]    s_hresp;
  modport master (
    output ovr_en, ovr_sel, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
           s_hrdata, s_hreadyout, s_hresp,
    input  m_hrdata, m_hready, m_hresp, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
           s_hwdata, s_hsel, s_hready
  );
  modport slave (
    input  ovr_en, ovr_sel, m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
           s_hrdata, s_hreadyout, s_hresp,
    output m_hrdata, m_hready, m_hresp, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
           s_hwdata, s_hsel, s_hready
  );
endinterface

// File: rtl/ahb_interconnect.sv
// ahb_interconnect: multi-manager AHB-Lite interconnect with arbitration, address decode and error satellite
module ahb_interconnect #(
  parameter int                    NUM_MGR  = 2,
  parameter int                    NUM_SAT  = 4,
  parameter int                    ARB_MODE = 0,
  parameter logic [32*NUM_SAT-1:0] SAT_BASE = {NUM_SAT{32'h0}},
  parameter logic [32*NUM_SAT-1:0] SAT_MASK = {NUM_SAT{32'hF000_0000}}
) (
  input logic clk,
  input logic nrst,
  ahb_interconnect_if.slave bus
);
  localparam int MW = NUM_MGR > 1 ? $clog2(NUM_MGR) : 1;
  localparam int SW = $clog2(NUM_SAT + 1);
  localparam logic [SW-1:0] DEF = SW'(NUM_SAT);
  typedef enum logic [1:0] {DP_NONE, DP_SAT, DP_ERR1, DP_ERR2} dp_e;
  dp_e dp_q, dp_d;
  logic [MW-1:0] owner_q, owner_d, dp_mgr_q, dp_mgr_d, rr_last_q, rr_last_d, req_win, win;
  logic [SW-1:0] dp_sat_q, dp_sat_d, hit;
  logic [31:0] o_haddr, sat_rdata, dp_rdata;
  logic [1:0] o_htrans;
  logic [2:0] o_hburst;
  logic hready, sat_rdy, sat_resp, dp_resp, any_req, arb;
  int rr_base;
  assign o_haddr  = bus.m_haddr[32*owner_q +: 32];
  assign o_htrans = bus.m_htrans[2*owner_q +: 2];
  assign o_hburst = bus.m_hburst[3*owner_q +: 3];
  assign bus.s_haddr  = o_haddr;
  assign bus.s_htrans = nrst ? 2'b00 : o_htrans;
  assign bus.s_hwrite = bus.m_hwrite[owner_q];
  assign bus.s_hsize  = bus.m_hsize[3*owner_q +: 3];
  assign bus.s_hburst = o_hburst;
  assign bus.s_hwdata = bus.m_hwdata[32*dp_mgr_q +: 32];
  // decode owner address; descending scan lets the lowest matching slot win, no match -> DEF
  always_comb begin
    hit = DEF;
    for (int s = NUM_SAT - 1; s >= 0; s--)
      if ((o_haddr & SAT_MASK[32*s +: 32]) == (SAT_BASE[32*s +: 32] & SAT_MASK[32*s +: 32])) hit = SW'(s);
  end
  // one-hot select and data-phase return path from the selected satellite
  always_comb begin
    bus.s_hsel = '0;
    sat_rdy = 1'b1;
    sat_resp = 1'b0;
    sat_rdata = '0;
    for (int s = 0; s < NUM_SAT; s++) begin
      bus.s_hsel[s] = !nrst && o_htrans[1] && hit == SW'(s);
      if (dp_sat_q == SW'(s)) begin
        sat_rdy = bus.s_hreadyout[s];
        sat_resp = bus.s_hresp[s];
        sat_rdata = bus.s_hrdata[32*s +: 32];
      end
    end
  end
  assign hready   = nrst || (dp_q == DP_SAT ? sat_rdy : dp_q != DP_ERR1);
  assign dp_resp  = dp_q == DP_SAT ? sat_resp : (dp_q == DP_ERR1 || dp_q == DP_ERR2);
  assign dp_rdata = dp_q == DP_SAT ? sat_rdata : 32'h0;
  assign bus.s_hready = hready;
  // per-manager response: data-phase manager and owner follow the bus, other requesters are stalled
  always_comb begin
    bus.m_hready = '0;
    bus.m_hresp = '0;
    bus.m_hrdata = '0;
    for (int m = 0; m < NUM_MGR; m++) begin
      bus.m_hready[m] = ((!nrst && dp_q != DP_NONE && dp_mgr_q == MW'(m)) || owner_q == MW'(m)) ? hready : (nrst || !bus.m_htrans[2*m+1]);
      bus.m_hresp[m] = !nrst && dp_q != DP_NONE && dp_mgr_q == MW'(m) && dp_resp;
      bus.m_hrdata[32*m +: 32] = (!nrst && dp_q != DP_NONE && dp_mgr_q == MW'(m)) ? dp_rdata : 32'h0;
    end
  end
  assign rr_base = ARB_MODE == 1 ? int'(rr_last_q) + 1 : 0;
  // pick the first requester scanning from rr_base; fixed priority scans from 0
  always_comb begin
    any_req = 1'b0;
    req_win = owner_q;
    for (int k = NUM_MGR - 1; k >= 0; k--)
      if (bus.m_htrans[2*((rr_base + k) % NUM_MGR) + 1]) begin
        any_req = 1'b1;
        req_win = MW'((rr_base + k) % NUM_MGR);
      end
  end
  assign win = bus.ovr_en ? (int'(bus.ovr_sel) >= NUM_MGR ? '0 : bus.ovr_sel) : req_win;
  assign arb = hready && (o_htrans == 2'b00 || (o_htrans == 2'b10 && o_hburst == 3'b000));
  // next state: ownership handover at arbitration points, data phase loads when the bus is ready
  always_comb begin
    owner_d = arb ? win : owner_q;
    rr_last_d = arb && (bus.ovr_en || any_req) ? win : rr_last_q;
    dp_d = dp_q;
    dp_mgr_d = dp_mgr_q;
    dp_sat_d = dp_sat_q;
    if (dp_q == DP_ERR1) dp_d = DP_ERR2;
    else if (hready) begin
      dp_d = !o_htrans[1] ? DP_NONE : hit == DEF ? DP_ERR1 : DP_SAT;
      dp_mgr_d = owner_q;
      dp_sat_d = hit;
    end
  end
  // state registers; reset drops any data phase in flight
  always_ff @(posedge clk)
    if (nrst) begin
      owner_q <= '0;
      rr_last_q <= MW'(NUM_MGR - 1);
      dp_q <= DP_NONE;
      dp_mgr_q <= '0;
      dp_sat_q <= DEF;
    end else begin
      owner_q <= owner_d;
      rr_last_q <= rr_last_d;
      dp_q <= dp_d;
      dp_mgr_q <= dp_mgr_d;
      dp_sat_q <= dp_sat_d;
    end
endmodule

// File: tb/tb_ahb_interconnect.sv
// tb_ahb_interconnect: directed checks of arbitration, decode, error satellite, override and reset
module tb_ahb_interconnect;
  localparam logic [127:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [1:0] IDLE = 2'b00, NS = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;
  logic clk = 1'b0;
  logic nrst_a = 1'b1, nrst_b = 1'b1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ahb_interconnect_if #(.NUM_MGR(2), .NUM_SAT(4)) ifa ();
  ahb_interconnect_if #(.NUM_MGR(2), .NUM_SAT(4)) ifb ();
  ahb_interconnect #(.NUM_MGR(2), .NUM_SAT(4), .ARB_MODE(0), .SAT_BASE(BASE)) dut_a (.clk(clk), .nrst(nrst_a), .bus(ifa));
  ahb_interconnect #(.NUM_MGR(2), .NUM_SAT(4), .ARB_MODE(1), .SAT_BASE(BASE)) dut_b (.clk(clk), .nrst(nrst_b), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mdrv(input int m, input logic [1:0] tr, input logic [2:0] bu, input logic [31:0] a);
    ifa.m_htrans[2*m +: 2] = tr;
    ifa.m_hburst[3*m +: 3] = bu;
    ifa.m_haddr[32*m +: 32] = a;
  endtask

  initial begin
    ifa.ovr_en = 1'b0;
    ifa.ovr_sel = '0;
    ifa.m_haddr = '0;
    ifa.m_htrans = '0;
    ifa.m_hwrite = '0;
    ifa.m_hsize = {2{3'b010}};
    ifa.m_hburst = '0;
    ifa.m_hwdata = {32'hBBBB_1111, 32'hAAAA_0000};
    ifa.s_hrdata = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1234_5678};
    ifa.s_hreadyout = '1;
    ifa.s_hresp = '0;
    ifb.ovr_en = 1'b0;
    ifb.ovr_sel = '0;
    ifb.m_haddr = {32'h1000_0000, 32'h0000_0000};
    ifb.m_htrans = {NS, NS};
    ifb.m_hwrite = '0;
    ifb.m_hsize = {2{3'b010}};
    ifb.m_hburst = '0;
    ifb.m_hwdata = '0;
    ifb.s_hrdata = '0;
    ifb.s_hreadyout = '1;
    ifb.s_hresp = '0;
    // reset with a pending request: bus must stay quiet
    mdrv(0, NS, SINGLE, 32'h10);
    #1;
    chk("rst_htrans", 32'(ifa.s_htrans), 0);
    chk("rst_hsel", 32'(ifa.s_hsel), 0);
    chk("rst_mhready", 32'(ifa.m_hready), 3);
    chk("rst_mhresp", 32'(ifa.m_hresp), 0);
    chk("rst_mhrdata", ifa.m_hrdata[31:0], 0);
    chk("rst_shready", 32'(ifa.s_hready), 1);
    tick;
    nrst_a = 1'b0;
    mdrv(0, IDLE, SINGLE, 32'h10);
    #1;
    chk("post_rst_mhready", 32'(ifa.m_hready), 3);
    chk("post_rst_htrans", 32'(ifa.s_htrans), 0);
    // M0 single read from RAM slot 0
    tick;
    mdrv(0, NS, SINGLE, 32'h10);
    #1;
    chk("t1_hsel", 32'(ifa.s_hsel), 1);
    chk("t1_haddr", ifa.s_haddr, 32'h10);
    chk("t1_htrans", 32'(ifa.s_htrans), 2);
    tick;
    mdrv(0, IDLE, SINGLE, 32'h10);
    #1;
    chk("t1_rdata", ifa.m_hrdata[31:0], 32'h1234_5678);
    chk("t1_mhready", 32'(ifa.m_hready), 3);
    chk("t1_mhresp", 32'(ifa.m_hresp), 0);
    // simultaneous requests, fixed priority
    tick;
    mdrv(0, NS, SINGLE, 32'h20);
    mdrv(1, NS, SINGLE, 32'h1000_0040);
    #1;
    chk("t2_haddr0", ifa.s_haddr, 32'h20);
    chk("t2_mhready0", 32'(ifa.m_hready), 1);
    chk("t2_hsel0", 32'(ifa.s_hsel), 1);
    tick;
    mdrv(0, IDLE, SINGLE, 32'h20);
    #1;
    chk("t2_mhready1", 32'(ifa.m_hready), 1);
    chk("t2_hsel1", 32'(ifa.s_hsel), 0);
    tick;
    #1;
    chk("t2_haddr_m1", ifa.s_haddr, 32'h1000_0040);
    chk("t2_hsel_m1", 32'(ifa.s_hsel), 2);
    chk("t2_mhready2", 32'(ifa.m_hready), 3);
    // M1 data phase with a wait state while M0 requests
    tick;
    mdrv(1, IDLE, SINGLE, 32'h1000_0040);
    mdrv(0, NS, SINGLE, 32'h30);
    ifa.s_hreadyout[1] = 1'b0;
    #1;
    chk("t2_wait_shready", 32'(ifa.s_hready), 0);
    chk("t2_wait_mhready", 32'(ifa.m_hready), 0);
    chk("t2_hwdata", ifa.s_hwdata, 32'hBBBB_1111);
    chk("t2_wait_haddr", ifa.s_haddr, 32'h1000_0040);
    tick;
    ifa.s_hreadyout[1] = 1'b1;
    #1;
    chk("t2_wait_end_mhready", 32'(ifa.m_hready), 2);
    chk("t2_wait_owner_held", ifa.s_haddr, 32'h1000_0040);
    chk("t2_rdata_m1", ifa.m_hrdata[63:32], 32'h2222_0001);
    tick;
    #1;
    chk("t2_haddr_m0", ifa.s_haddr, 32'h30);
    chk("t2_mhready3", 32'(ifa.m_hready), 3);
    tick;
    mdrv(0, IDLE, SINGLE, 32'h30);
    #1;
    chk("t2_rdata_m0", ifa.m_hrdata[31:0], 32'h1234_5678);
    // M0 INCR4 burst with M1 waiting
    tick;
    mdrv(0, NS, INCR4, 32'h100);
    mdrv(1, NS, SINGLE, 32'h1000_0080);
    #1;
    chk("t4_b0_haddr", ifa.s_haddr, 32'h100);
    chk("t4_b0_mhready", 32'(ifa.m_hready), 1);
    tick;
    mdrv(0, SEQ, INCR4, 32'h104);
    #1;
    chk("t4_b1_haddr", ifa.s_haddr, 32'h104);
    chk("t4_b1_mhready", 32'(ifa.m_hready), 1);
    tick;
    mdrv(0, SEQ, INCR4, 32'h108);
    #1;
    chk("t4_b2_haddr", ifa.s_haddr, 32'h108);
    tick;
    mdrv(0, SEQ, INCR4, 32'h10C);
    #1;
    chk("t4_b3_haddr", ifa.s_haddr, 32'h10C);
    chk("t4_b3_mhready", 32'(ifa.m_hready), 1);
    tick;
    mdrv(0, IDLE, SINGLE, 32'h10C);
    #1;
    chk("t4_last_mhready", 32'(ifa.m_hready), 1);
    chk("t4_last_htrans", 32'(ifa.s_htrans), 0);
    tick;
    #1;
    chk("t4_m1_haddr", ifa.s_haddr, 32'h1000_0080);
    chk("t4_m1_hsel", 32'(ifa.s_hsel), 2);
    chk("t4_m1_mhready", 32'(ifa.m_hready), 3);
    tick;
    mdrv(1, IDLE, SINGLE, 32'h1000_0080);
    // unmapped read to the error satellite
    tick;
    mdrv(1, NS, SINGLE, 32'hF000_0000);
    #1;
    chk("t5_hsel", 32'(ifa.s_hsel), 0);
    chk("t5_htrans", 32'(ifa.s_htrans), 2);
    tick;
    mdrv(1, IDLE, SINGLE, 32'hF000_0000);
    #1;
    chk("t5_c1_mhready", 32'(ifa.m_hready), 1);
    chk("t5_c1_mhresp", 32'(ifa.m_hresp), 2);
    chk("t5_c1_shready", 32'(ifa.s_hready), 0);
    chk("t5_c1_rdata", ifa.m_hrdata[63:32], 0);
    tick;
    #1;
    chk("t5_c2_mhready", 32'(ifa.m_hready), 3);
    chk("t5_c2_mhresp", 32'(ifa.m_hresp), 2);
    tick;
    #1;
    chk("t5_after_mhresp", 32'(ifa.m_hresp), 0);
    // forced grant to M1 during an M0 single stream
    tick;
    mdrv(0, NS, SINGLE, 32'h40);
    #1;
    chk("t6_stall_m0", 32'(ifa.m_hready), 2);
    tick;
    ifa.ovr_en = 1'b1;
    ifa.ovr_sel = 1'b1;
    #1;
    chk("t6_m0_haddr", ifa.s_haddr, 32'h40);
    chk("t6_m0_hsel", 32'(ifa.s_hsel), 1);
    tick;
    mdrv(0, NS, SINGLE, 32'h44);
    #1;
    chk("t6_ovr_haddr", ifa.s_haddr, 32'hF000_0000);
    chk("t6_ovr_htrans", 32'(ifa.s_htrans), 0);
    tick;
    #1;
    chk("t6_ovr_stall0", 32'(ifa.m_hready), 2);
    tick;
    ifa.ovr_en = 1'b0;
    #1;
    chk("t6_ovr_stall1", 32'(ifa.m_hready), 2);
    chk("t6_ovr_owner", ifa.s_haddr, 32'hF000_0000);
    tick;
    #1;
    chk("t6_release_haddr", ifa.s_haddr, 32'h44);
    chk("t6_release_mhready", 32'(ifa.m_hready), 3);
    // reset while a stalled data phase is in flight
    tick;
    mdrv(0, IDLE, SINGLE, 32'h44);
    ifa.s_hreadyout[0] = 1'b0;
    nrst_a = 1'b1;
    #1;
    chk("rst_mid_hsel", 32'(ifa.s_hsel), 0);
    chk("rst_mid_shready", 32'(ifa.s_hready), 1);
    chk("rst_mid_mhready", 32'(ifa.m_hready), 3);
    chk("rst_mid_mhresp", 32'(ifa.m_hresp), 0);
    tick;
    nrst_a = 1'b0;
    #1;
    chk("rst_drop_shready", 32'(ifa.s_hready), 1);
    chk("rst_drop_mhready", 32'(ifa.m_hready), 3);
    // round-robin: both managers request SINGLE every cycle
    tick;
    nrst_b = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick;
      chk($sformatf("t3_rr_c%0d", c), ifb.s_haddr, (c % 2 == 1) ? 32'h0 : 32'h1000_0000);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
